// File: rtl/con_pkg.sv
// Shared types and default sizes for the data-memory console port.
package con_pkg;

   localparam int CON_ADDR_BITS  = 10;
   localparam int CON_WORD_WIDTH = 32;
   localparam int CON_STRB_W     = 4;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD_WAIT,
      ST_RSP,
      ST_DUMP_RD,
      ST_DUMP_WAIT,
      ST_DUMP_RSP
   } con_state_t;

endpackage

// File: rtl/con_dump_cursor.sv
// Loadable wrapping word-address counter with an inclusive end-address compare.
module con_dump_cursor #(
   parameter int ADDR_BITS = 10
) (
   input  logic                 CLK,
   input  logic                 rst,
   input  logic                 load,
   input  logic [ADDR_BITS-1:0] base,
   input  logic [ADDR_BITS-1:0] last,
   input  logic                 advance,
   output logic [ADDR_BITS-1:0] cur_next,
   output logic                 at_last
);

   logic [ADDR_BITS-1:0] cur;
   logic [ADDR_BITS-1:0] last_q;

   always_ff @(posedge CLK) begin
      if (rst) begin
         cur    <= '0;
         last_q <= '0;
      end else if (load) begin
         cur    <= base;
         last_q <= last;
      end else if (advance) begin
         cur    <= cur_next;
      end
   end

   // Natural overflow gives the modulo-2^ADDR_BITS wrap through address 0.
   assign cur_next = cur + ADDR_BITS'(1);
   assign at_last  = (cur == last_q);

endmodule

// File: rtl/datamem_con_port.sv
// Console debug responder for the data memory secondary port.
// Optional dump engine compiled in when CON_DUMP_EN is defined.
module datamem_con_port
   import con_pkg::*;
#(
   parameter int ADDR_BITS  = CON_ADDR_BITS,
   parameter int WORD_WIDTH = CON_WORD_WIDTH,
   parameter int RD_LATENCY = 1
) (
   input  logic                  CLK,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [CON_STRB_W-1:0] req_we,
   input  logic [ADDR_BITS-1:0]  req_addr,
   input  logic [WORD_WIDTH-1:0] req_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [WORD_WIDTH-1:0] rsp_data,
   output logic [ADDR_BITS-1:0]  rsp_addr,
   input  logic                  dump_start,
   input  logic [ADDR_BITS-1:0]  dump_base,
   input  logic [ADDR_BITS-1:0]  dump_last,
   output logic                  dump_done,
   output logic                  mem_en,
   output logic [CON_STRB_W-1:0] mem_we,
   output logic [ADDR_BITS-1:0]  mem_addr,
   output logic [WORD_WIDTH-1:0] mem_wdata,
   input  logic [WORD_WIDTH-1:0] mem_rdata,
   output logic                  busy
);

   localparam int               CNT_W = $clog2(RD_LATENCY + 2);
   localparam logic [CNT_W-1:0] LAT   = CNT_W'(RD_LATENCY);

   con_state_t           state, state_next;
   logic [CNT_W-1:0]     cnt;
   logic                 dump_go;
   logic                 cur_last;
   logic [ADDR_BITS-1:0] cur_next;
   logic                 take_req;
   logic                 wr_fire;
   logic                 rd_fire;
   logic                 in_wait;
   logic                 lat_done;
   logic                 dump_adv;
   logic                 dump_fin;

`ifdef CON_DUMP_EN
   assign dump_go = dump_start && (state == ST_IDLE);

   con_dump_cursor #(
      .ADDR_BITS (ADDR_BITS)
   ) u_cursor (
      .CLK      (CLK),
      .rst      (rst),
      .load     (dump_go),
      .base     (dump_base),
      .last     (dump_last),
      .advance  (dump_adv),
      .cur_next (cur_next),
      .at_last  (cur_last)
   );
`else
   logic unused_dump;
   assign unused_dump = ^{dump_start, dump_base, dump_last};
   assign dump_go     = 1'b0;
   assign cur_next    = '0;
   assign cur_last    = 1'b0;
`endif

   // A dump request in the same IDLE cycle takes priority; the request waits.
   assign req_ready = (state == ST_IDLE) && !rst && !dump_go;
   assign take_req  = req_valid && req_ready;
   assign wr_fire   = take_req && (req_we != '0);
   assign rd_fire   = take_req && (req_we == '0);

   assign in_wait   = (state == ST_RD_WAIT) || (state == ST_DUMP_WAIT);
   assign lat_done  = (cnt == LAT);
   assign dump_adv  = (state == ST_DUMP_RSP) && rsp_ready && !cur_last;
   assign dump_fin  = (state == ST_DUMP_RSP) && rsp_ready && cur_last;

   assign rsp_valid = (state == ST_RSP) || (state == ST_DUMP_RSP);
   assign busy      = (state != ST_IDLE);

   always_comb begin
      state_next = state;
      unique case (state)
         ST_IDLE: begin
            if (dump_go) begin
               state_next = ST_DUMP_RD;
            end else if (rd_fire) begin
               state_next = ST_RD_WAIT;
            end
         end
         ST_RD_WAIT: begin
            if (lat_done) state_next = ST_RSP;
         end
         ST_RSP: begin
            if (rsp_ready) state_next = ST_IDLE;
         end
         ST_DUMP_RD: begin
            state_next = ST_DUMP_WAIT;
         end
         ST_DUMP_WAIT: begin
            if (lat_done) state_next = ST_DUMP_RSP;
         end
         ST_DUMP_RSP: begin
            if (rsp_ready) state_next = cur_last ? ST_IDLE : ST_DUMP_RD;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (rst) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         mem_en    <= 1'b0;
         mem_we    <= '0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         rsp_data  <= '0;
         rsp_addr  <= '0;
         dump_done <= 1'b0;
      end else begin
         state     <= state_next;
         mem_en    <= 1'b0;
         mem_we    <= '0;
         dump_done <= dump_fin;

         // The enable cycle is the one right after the issuing edge.
         if (wr_fire) begin
            mem_en    <= 1'b1;
            mem_we    <= req_we;
            mem_addr  <= req_addr;
            mem_wdata <= req_wdata;
         end else if (rd_fire) begin
            mem_en    <= 1'b1;
            mem_addr  <= req_addr;
         end else if (dump_go) begin
            mem_en    <= 1'b1;
            mem_addr  <= dump_base;
         end else if (dump_adv) begin
            mem_en    <= 1'b1;
            mem_addr  <= cur_next;
         end

         // DUMP_RD stands in for the first wait cycle of a single read.
         if ((in_wait && !lat_done) || (state == ST_DUMP_RD)) begin
            cnt <= cnt + CNT_W'(1);
         end else begin
            cnt <= '0;
         end

         if (in_wait && lat_done) begin
            rsp_data <= mem_rdata;
            rsp_addr <= mem_addr;
         end
      end
   end

endmodule

// File: tb/tb_datamem_con_port.sv
// Directed bench for datamem_con_port with a byte-lane memory model (RD_LATENCY=1).
module tb_datamem_con_port;

   logic        CLK;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [3:0]  req_we;
   logic [9:0]  req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_data;
   logic [9:0]  rsp_addr;
   logic        dump_start;
   logic [9:0]  dump_base;
   logic [9:0]  dump_last;
   logic        dump_done;
   logic        mem_en;
   logic [3:0]  mem_we;
   logic [9:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        busy;

   int n_vec = 0;
   int n_err = 0;

   datamem_con_port #(
      .ADDR_BITS  (10),
      .WORD_WIDTH (32),
      .RD_LATENCY (1)
   ) dut (
      .CLK        (CLK),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_data   (rsp_data),
      .rsp_addr   (rsp_addr),
      .dump_start (dump_start),
      .dump_base  (dump_base),
      .dump_last  (dump_last),
      .dump_done  (dump_done),
      .mem_en     (mem_en),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .busy       (busy)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Unwritten words read back as their own address.
   logic [31:0] mem [int];
   always @(posedge CLK) begin
      logic [31:0] w;
      if (mem_en) begin
         w = mem.exists(int'(mem_addr)) ? mem[int'(mem_addr)] : 32'(mem_addr);
         mem_rdata <= w;
         for (int b = 0; b < 4; b++) begin
            if (mem_we[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
         end
         mem[int'(mem_addr)] = w;
      end
   end

   task automatic tick();
      @(negedge CLK);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   logic [9:0]  ra [0:3];
   logic [31:0] rd [0:3];
   int          n_rsp;
   int          n_done;
   int          t_prev;

   initial begin
      mem_rdata  = '0;
      rst        = 1'b1;
      req_valid  = 1'b0;
      req_we     = '0;
      req_addr   = '0;
      req_wdata  = '0;
      rsp_ready  = 1'b0;
      dump_start = 1'b0;
      dump_base  = '0;
      dump_last  = '0;
      tick();
      tick();
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_mem_en", 32'(mem_en), 32'd0);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_dump_done", 32'(dump_done), 32'd0);
      chk("rst_rsp_data", rsp_data, 32'd0);
      chk("rst_mem_addr", 32'(mem_addr), 32'd0);
      rst = 1'b0;
      #1;
      chk("rel_req_ready", 32'(req_ready), 32'd1);

      // Full-word write then read-back at 0x005
      req_valid = 1'b1; req_we = 4'hF; req_addr = 10'h005; req_wdata = 32'hDEADBEEF;
      tick();
      chk("wr_mem_en", 32'(mem_en), 32'd1);
      chk("wr_mem_we", 32'(mem_we), 32'hF);
      chk("wr_mem_addr", 32'(mem_addr), 32'h005);
      chk("wr_mem_wdata", mem_wdata, 32'hDEADBEEF);
      chk("wr_req_ready", 32'(req_ready), 32'd1);
      req_we = 4'h0;
      tick();
      chk("rd_mem_en", 32'(mem_en), 32'd1);
      chk("rd_mem_we", 32'(mem_we), 32'd0);
      chk("rd_busy", 32'(busy), 32'd1);
      chk("rd_req_ready", 32'(req_ready), 32'd0);
      req_valid = 1'b0;
      tick();
      chk("rd_rsp_valid_early", 32'(rsp_valid), 32'd0);
      tick();
      chk("rd_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("rd_rsp_data", rsp_data, 32'hDEADBEEF);
      chk("rd_rsp_addr", 32'(rsp_addr), 32'h005);
      rsp_ready = 1'b1;
      tick();
      chk("rd_done_valid", 32'(rsp_valid), 32'd0);
      chk("rd_done_ready", 32'(req_ready), 32'd1);

      // Byte-lane merge at 0x010, then read under backpressure
      rsp_ready = 1'b0;
      req_valid = 1'b1; req_we = 4'hF; req_addr = 10'h010; req_wdata = 32'h11223344;
      tick();
      req_we = 4'b0010; req_wdata = 32'h0000AA00;
      tick();
      chk("bwr_mem_we", 32'(mem_we), 32'h2);
      chk("bwr_mem_wdata", mem_wdata, 32'h0000AA00);
      req_we = 4'h0;
      tick();
      tick();
      tick();
      chk("bp_rsp_valid0", 32'(rsp_valid), 32'd1);
      chk("bp_rsp_data0", rsp_data, 32'h1122AA44);
      chk("bp_rsp_addr0", 32'(rsp_addr), 32'h010);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
         chk("bp_rsp_data", rsp_data, 32'h1122AA44);
         chk("bp_req_ready", 32'(req_ready), 32'd0);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      tick();
      chk("bp_release_busy", 32'(busy), 32'd0);
      chk("bp_release_ready", 32'(req_ready), 32'd1);

      // Wrapping dump 0x3FE..0x001
      dump_base = 10'h3FE; dump_last = 10'h001; dump_start = 1'b1;
      tick();
      dump_start = 1'b0;
      n_rsp = 0; n_done = 0; t_prev = 0;
      for (int t = 1; t <= 16; t++) begin
`ifdef CON_DUMP_EN
         chk("dump_mem_we", 32'(mem_we), 32'd0);
`endif
         if (rsp_valid && n_rsp < 4) begin
            ra[n_rsp] = rsp_addr;
            rd[n_rsp] = rsp_data;
            if (n_rsp > 0) chk("dump_period", 32'(t - t_prev), 32'd3);
            t_prev = t;
            n_rsp++;
         end
         if (dump_done) n_done++;
         tick();
      end
`ifdef CON_DUMP_EN
      chk("dump_count", 32'(n_rsp), 32'd4);
      chk("dump_done_cnt", 32'(n_done), 32'd1);
      if (n_rsp == 4) begin
         chk("dump_a0", 32'(ra[0]), 32'h3FE);
         chk("dump_d0", rd[0], 32'h3FE);
         chk("dump_a1", 32'(ra[1]), 32'h3FF);
         chk("dump_d1", rd[1], 32'h3FF);
         chk("dump_a2", 32'(ra[2]), 32'h000);
         chk("dump_d2", rd[2], 32'h000);
         chk("dump_a3", 32'(ra[3]), 32'h001);
         chk("dump_d3", rd[3], 32'h001);
      end
`else
      chk("nodump_count", 32'(n_rsp), 32'd0);
      chk("nodump_done", 32'(n_done), 32'd0);
      chk("nodump_busy", 32'(busy), 32'd0);
`endif

      // Dump and read request in the same cycle
      dump_base = 10'h020; dump_last = 10'h020; dump_start = 1'b1;
      req_valid = 1'b1; req_we = 4'h0; req_addr = 10'h005;
      #1;
`ifdef CON_DUMP_EN
      chk("coll_req_ready", 32'(req_ready), 32'd0);
`else
      chk("coll_req_ready", 32'(req_ready), 32'd1);
`endif
      n_rsp = 0; n_done = 0;
      for (int t = 0; t < 20; t++) begin
         if (req_valid && req_ready) begin
            tick();
            req_valid = 1'b0;
         end else begin
            tick();
         end
         dump_start = 1'b0;
         if (rsp_valid && n_rsp < 2) begin
            ra[n_rsp] = rsp_addr;
            rd[n_rsp] = rsp_data;
            n_rsp++;
         end
         if (dump_done) n_done++;
      end
`ifdef CON_DUMP_EN
      chk("coll_count", 32'(n_rsp), 32'd2);
      chk("coll_done", 32'(n_done), 32'd1);
      if (n_rsp == 2) begin
         chk("coll_a0", 32'(ra[0]), 32'h020);
         chk("coll_d0", rd[0], 32'h020);
         chk("coll_a1", 32'(ra[1]), 32'h005);
         chk("coll_d1", rd[1], 32'hDEADBEEF);
      end
`else
      chk("coll_count", 32'(n_rsp), 32'd1);
      chk("coll_done", 32'(n_done), 32'd0);
      if (n_rsp == 1) begin
         chk("coll_a0", 32'(ra[0]), 32'h005);
         chk("coll_d0", rd[0], 32'hDEADBEEF);
      end
`endif

      // Reset while waiting on read data
      req_valid = 1'b1; req_we = 4'h0; req_addr = 10'h010;
      tick();
      chk("abort_pre_busy", 32'(busy), 32'd1);
      req_valid = 1'b0;
      rst = 1'b1;
      tick();
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("abort_req_ready", 32'(req_ready), 32'd0);
      chk("abort_mem_en", 32'(mem_en), 32'd0);
      tick();
      chk("abort_req_ready2", 32'(req_ready), 32'd0);
      rst = 1'b0;
      #1;
      chk("abort_rel_ready", 32'(req_ready), 32'd1);
      tick();
      tick();
      chk("abort_no_rsp", 32'(rsp_valid), 32'd0);
      chk("abort_no_done", 32'(dump_done), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
